satd_generator: RTL and testbench

SATD_GENERATOR -- requirements
Module: satd_generator

---
 rtl/fme_pkg.sv | 9 +
 rtl/satd_generator_satd4x4.sv | 41 ++++
 rtl/satd_generator.sv | 46 ++++
 tb/tb_satd_generator.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// fme_pkg: shared widths and sizes for the fractional motion estimation SATD search.
package fme_pkg;
  localparam int NUM_CAND = 9;
  localparam int PIX_W    = 8;
  localparam int SATD_W   = 16;
  localparam int BLK_PIX  = 16;
  localparam int RES_W    = PIX_W + 1;
  localparam int COEF_W   = RES_W + 4;
endpackage

// File: rtl/satd_generator_satd4x4.sv
// satd4x4: combinational 4x4 Hadamard SATD of a block against one constant predictor.
module satd4x4 #(
  parameter int PIX_W  = fme_pkg::PIX_W,
  parameter int SATD_W = fme_pkg::SATD_W
) (
  input  logic [16*PIX_W-1:0] blk,
  input  logic [PIX_W-1:0]    cand,
  output logic [SATD_W-1:0]   satd
);
  localparam int RES_W  = PIX_W + 1;
  localparam int COEF_W = RES_W + 4;
  logic signed [RES_W-1:0]  w_res [16];
  logic signed [COEF_W-1:0] w_d   [16];
  logic signed [COEF_W-1:0] w_m   [16];
  logic signed [COEF_W-1:0] w_t   [16];
  logic        [COEF_W-1:0] w_abs [16];
  // Row pass then column pass of the butterfly; each output order matches the H4 rows.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_res[i] = $signed({1'b0, blk[i*PIX_W +: PIX_W]}) - $signed({1'b0, cand});
      w_d[i]   = COEF_W'(w_res[i]);
    end
    for (int r = 0; r < 4; r++) begin
      w_m[4*r+0] = (w_d[4*r] + w_d[4*r+1]) + (w_d[4*r+2] + w_d[4*r+3]);
      w_m[4*r+1] = (w_d[4*r] + w_d[4*r+1]) - (w_d[4*r+2] + w_d[4*r+3]);
      w_m[4*r+2] = (w_d[4*r] - w_d[4*r+1]) - (w_d[4*r+2] - w_d[4*r+3]);
      w_m[4*r+3] = (w_d[4*r] - w_d[4*r+1]) + (w_d[4*r+2] - w_d[4*r+3]);
    end
    for (int c = 0; c < 4; c++) begin
      w_t[c]    = (w_m[c] + w_m[4+c]) + (w_m[8+c] + w_m[12+c]);
      w_t[4+c]  = (w_m[c] + w_m[4+c]) - (w_m[8+c] + w_m[12+c]);
      w_t[8+c]  = (w_m[c] - w_m[4+c]) - (w_m[8+c] - w_m[12+c]);
      w_t[12+c] = (w_m[c] - w_m[4+c]) + (w_m[8+c] - w_m[12+c]);
    end
    satd = '0;
    for (int i = 0; i < 16; i++) begin
      w_abs[i] = w_t[i][COEF_W-1] ? COEF_W'(-w_t[i]) : COEF_W'(w_t[i]);
      satd     = satd + {{(SATD_W-COEF_W){1'b0}}, w_abs[i]};
    end
  end
endmodule

// File: rtl/satd_generator.sv
// satd_generator: scans all candidate predictors one per clock and keeps the lowest-SATD one.
module satd_generator #(
  parameter int NUM_CAND = fme_pkg::NUM_CAND,
  parameter int PIX_W    = fme_pkg::PIX_W,
  parameter int SATD_W   = fme_pkg::SATD_W
) (
  input  logic                                 clk,
  input  logic                                 rst1,
  input  logic [NUM_CAND*PIX_W-1:0]            half_quat,
  input  logic [fme_pkg::BLK_PIX*PIX_W-1:0]    cur_pix,
  output logic [3:0]                           best,
  output logic [SATD_W-1:0]                    min_satd,
  output logic                                 done
);
  logic [3:0]        r_idx;
  logic [3:0]        r_best;
  logic [SATD_W-1:0] r_min;
  logic              r_done;
  logic [SATD_W-1:0] w_satd;
  logic              w_last;
  satd4x4 #(.PIX_W(PIX_W), .SATD_W(SATD_W)) u_satd (
    .blk  (cur_pix),
    .cand (half_quat[r_idx*PIX_W +: PIX_W]),
    .satd (w_satd)
  );
  assign w_last = r_idx == 4'(NUM_CAND-1);
  // Strict less-than keeps the lowest index on ties; done freezes everything until reset.
  always_ff @(posedge clk or posedge rst1) begin
    if (rst1) begin
      r_idx  <= '0;
      r_best <= '0;
      r_min  <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      if (r_idx == '0 || w_satd < r_min) begin
        r_min  <= w_satd;
        r_best <= r_idx;
      end
      r_done <= w_last;
      r_idx  <= w_last ? r_idx : r_idx + 4'd1;
    end
  end
  assign best     = r_best;
  assign min_satd = r_min;
  assign done     = r_done;
endmodule

// File: tb/tb_satd_generator.sv
// tb_satd_generator: table-driven and corner-case checks of satd_generator with a result scoreboard.
module tb_satd_generator;
  typedef struct {
    logic [71:0]  hq;
    logic [127:0] cp;
    logic [3:0]   best;
    logic [15:0]  ms;
  } vec_t;
  typedef struct {
    logic [3:0]  best;
    logic [15:0] ms;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst1 = 1'b1;
  logic [71:0]  half_quat = '0;
  logic [127:0] cur_pix = '0;
  logic [3:0]   best;
  logic [15:0]  min_satd;
  logic         done;
  int           n_vec = 0;
  int           n_bad = 0;
  exp_t         sbq[$];
  vec_t         vecs[7];
  satd_generator dut (
    .clk       (clk),
    .rst1      (rst1),
    .half_quat (half_quat),
    .cur_pix   (cur_pix),
    .best      (best),
    .min_satd  (min_satd),
    .done      (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Direct matrix product H*D*H^T, independent of the butterfly structure.
  function automatic int satd_ref(input logic [127:0] cp, input logic [7:0] c);
    int h[4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
    int d[4][4];
    int s = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        d[a][b] = int'(cp[(4*a+b)*8 +: 8]) - int'(c);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int t = 0;
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++)
            t += h[i][a] * d[a][b] * h[j][b];
        s += (t < 0) ? -t : t;
      end
    return s;
  endfunction
  function automatic vec_t model_vec(input logic [71:0] hq, input logic [127:0] cp);
    vec_t v;
    int bs = 0;
    int bi = 0;
    v.hq = hq;
    v.cp = cp;
    for (int k = 0; k < 9; k++) begin
      int s = satd_ref(cp, hq[k*8 +: 8]);
      if (k == 0 || s < bs) begin
        bs = s;
        bi = k;
      end
    end
    v.best = 4'(bi);
    v.ms = 16'(bs);
    return v;
  endfunction
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n < 9) chk({name, " early_done"}, int'(done), 0);
    end
    chk({name, " done_edge"}, n, 9);
  endtask
  task automatic check_result(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({name, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({name, " best"}, int'(best), int'(e.best));
    chk({name, " min_satd"}, int'(min_satd), int'(e.ms));
    repeat (3) @(negedge clk);
    chk({name, " hold_done"}, int'(done), 1);
    chk({name, " hold_best"}, int'(best), int'(e.best));
    chk({name, " hold_min"}, int'(min_satd), int'(e.ms));
  endtask
  task automatic run(input string name, input vec_t v);
    int n;
    rst1 = 1'b1;
    half_quat = v.hq;
    cur_pix = v.cp;
    sbq.push_back('{best: v.best, ms: v.ms});
    @(negedge clk);
    chk({name, " rst_done"}, int'(done), 0);
    chk({name, " rst_best"}, int'(best), 0);
    chk({name, " rst_min"}, int'(min_satd), 0);
    rst1 = 1'b0;
    wait_done(name, n);
    check_result(name);
  endtask
  initial begin
    int n;
    logic [127:0] r_cp;
    logic [71:0]  r_hq;
    vecs[0] = '{{8'd90, 8'd90, 8'd90, 8'd100, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90}, {16{8'd100}}, 4'd5, 16'd0};
    vecs[1] = '{{8'd80, 8'd70, 8'd60, 8'd45, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0}, {16{8'd50}}, 4'd5, 16'd80};
    vecs[2] = '{{9{8'd7}}, {16{8'd3}}, 4'd0, 16'd64};
    vecs[3] = '{72'd0, {120'd0, 8'd16}, 4'd0, 16'd256};
    vecs[4] = '{{8'd254, 64'd0}, {16{8'd255}}, 4'd8, 16'd16};
    for (int r = 5; r < 7; r++) begin
      for (int i = 0; i < 16; i++) r_cp[i*8 +: 8] = 8'($urandom_range(255));
      for (int k = 0; k < 9; k++) r_hq[k*8 +: 8] = 8'($urandom_range(255));
      vecs[r] = model_vec(r_hq, r_cp);
    end
    for (int v = 0; v < 7; v++) run($sformatf("vec%0d", v), vecs[v]);
    // Abort after the 4th edge, then a full restart.
    rst1 = 1'b1;
    half_quat = vecs[1].hq;
    cur_pix = vecs[1].cp;
    @(negedge clk);
    rst1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort pre_best", int'(best), 3);
    chk("abort pre_min", int'(min_satd), 320);
    rst1 = 1'b1;
    #1;
    chk("abort async_done", int'(done), 0);
    chk("abort async_best", int'(best), 0);
    chk("abort async_min", int'(min_satd), 0);
    sbq.push_back('{best: vecs[1].best, ms: vecs[1].ms});
    @(negedge clk);
    rst1 = 1'b0;
    wait_done("abort", n);
    check_result("abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
